// File: rtl/branch_flag_ctrl_pkg.sv
// Shared types, flag indices and the condition-code evaluator for the branch/flag controller.
package pipe_ctrl_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_V  = 1;
  localparam int unsigned FLAG_C  = 0;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_CBZ  = 2'b10,
    BR_COND = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_HS, COND_LO,
    COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT,
    COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FLAGS,
    WAIT_OPND
  } bfc_state_e;

  // Evaluate a B.cond condition against an {N,Z,V,C} flag vector; AL and NV both mean always.
  function automatic logic cond_eval(input logic [FLAGS_W-1:0] flags, input cond_e cond);
    logic n, z, v, c, res;
    n   = flags[FLAG_N];
    z   = flags[FLAG_Z];
    v   = flags[FLAG_V];
    c   = flags[FLAG_C];
    res = 1'b1;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_HS: res = c;
      COND_LO: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !(c && !z);
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = !(!z && (n == v));
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_flag_ctrl_zero_detect64.sv
// Wide zero detector: asserts zero_o when every bit of data_i is clear.
module zero_detect64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             zero_o
);

  // Reduction NOR over the full operand.
  assign zero_o = ~|data_i;

endmodule

// File: rtl/branch_flag_ctrl.sv
// Branch resolution and NZVC flag control for ID/EX: flag register, hazard stall FSM,
// registered taken/flush pulse and a sticky stall-timeout error.
module branch_flag_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ex_valid,
  input  logic               ex_set_flags,
  input  logic [WIDTH-1:0]   ex_result,
  input  logic               ex_negative,
  input  logic               ex_overflow,
  input  logic               ex_carry,
  input  logic               id_valid,
  input  logic [1:0]         id_br_type,
  input  logic [3:0]         id_cond,
  input  logic [WIDTH-1:0]   id_operand,
  input  logic               id_operand_ready,
  output logic               stall,
  output logic               br_taken,
  output logic               flush,
  output logic [FLAGS_W-1:0] flags_q,
  output logic               stall_err
);

  localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

  bfc_state_e               state_q, state_d;
  logic [FLAGS_W-1:0]       flags_d;
  logic                     br_taken_q, br_taken_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic                     stall_err_q, stall_err_d;
  logic                     ex_zero, opnd_zero;
  logic                     flag_wr, br, resolve, taken, stall_raw;
  br_type_e                 br_type;

  zero_detect64 #(.WIDTH(WIDTH)) u_zd_ex   (.data_i(ex_result),  .zero_o(ex_zero));
  zero_detect64 #(.WIDTH(WIDTH)) u_zd_opnd (.data_i(id_operand), .zero_o(opnd_zero));

  assign br_type = br_type_e'(id_br_type);
  assign flag_wr = ex_valid && ex_set_flags;
  // An ID instruction seen during the flush cycle is already squashed.
  assign br      = id_valid && !br_taken_q && (br_type != BR_NONE);

  // Branch outcome from the current ID instruction and the committed flags.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_B:    taken = 1'b1;
      BR_CBZ:  taken = opnd_zero;
      BR_COND: taken = cond_eval(flags_q, cond_e'(id_cond));
      default: taken = 1'b0;
    endcase
  end

  // Hazard FSM next-state, stall and resolve decisions.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    resolve   = 1'b0;
    case (state_q)
      IDLE: begin
        if (br) begin
          if (br_type == BR_COND && flag_wr) begin
            state_d   = WAIT_FLAGS;
            stall_raw = 1'b1;
          end else if (br_type == BR_CBZ && !id_operand_ready) begin
            state_d   = WAIT_OPND;
            stall_raw = 1'b1;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      WAIT_FLAGS: begin
        state_d = IDLE;
        resolve = br;
      end
      WAIT_OPND: begin
        if (!br) begin
          state_d = IDLE;
        end else if (!id_operand_ready) begin
          stall_raw = 1'b1;
        end else begin
          state_d = IDLE;
          resolve = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted.
  assign stall = stall_raw && reset_n;

  // Flag capture, pulse generation and stall-length tracking.
  always_comb begin
    flags_d     = flags_q;
    stall_cnt_d = '0;
    br_taken_d  = resolve && taken;
    stall_err_d = stall_err_q;
    if (flag_wr) begin
      flags_d = {ex_negative, ex_zero, ex_overflow, ex_carry};
    end
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == CNT_W'(MAX_STALL)) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
      if (stall_cnt_q == CNT_W'(MAX_STALL)) begin
        stall_err_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      flags_q     <= '0;
      br_taken_q  <= 1'b0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      br_taken_q  <= br_taken_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign br_taken  = br_taken_q;
  assign flush     = br_taken_q;
  assign stall_err = stall_err_q;

endmodule
